// File: rtl/spi_reg_bridge_pkg.sv
// rtl/spi_reg_bridge_pkg.sv - shared FSM state and command encodings for spi_reg_bridge
package spi_reg_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } state_e;

    localparam logic CMD_WRITE = 1'b1;
    localparam logic CMD_READ  = 1'b0;

endpackage

// File: rtl/spi_reg_bridge_sync.sv
// rtl/spi_reg_bridge_sync.sv - multi-stage flop synchronizer for a bundle of independent async bits
module spi_reg_bridge_sync #(
    parameter int               STAGES    = 2,
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - SPI mode-0 slave to register bus bridge; SPI_REG_BRIDGE_BURST_EN enables auto-increment bursts
module spi_reg_bridge
    import spi_reg_bridge_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              spi_cs_n,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] reg_addr,
    input  logic [DATA_W-1:0] reg_data_i,
    output logic [DATA_W-1:0] reg_data_o,
    output logic              reg_data_o_dv,
    output logic              reg_rd_strobe
);

    // ADDR_W never exceeds 8 and DATA_W is at least 8, so DATA_W sizes the shared bit counter
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [2:0] sync_w;
    logic       s_cs_n, s_sclk, s_mosi;

    spi_reg_bridge_sync #(
        .STAGES    (SYNC_STAGES),
        .WIDTH     (3),
        .RESET_VAL (3'b100)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   ({spi_cs_n, spi_clk, spi_mosi}),
        .q_o   (sync_w)
    );

    assign {s_cs_n, s_sclk, s_mosi} = sync_w;

    state_e            state_q;
    logic              sclk_q, cs_q;
    logic              cmd_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [ADDR_W-1:0] addr_sh_q, reg_addr_q;
    logic [DATA_W-1:0] rx_q, tx_q, reg_data_o_q;
    logic              dv_q, load_q, inc_q;

    logic              sclk_rise, sclk_fall, cs_fall;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] rx_d;

    assign sclk_rise = s_sclk & ~sclk_q;
    assign sclk_fall = ~s_sclk & sclk_q;
    assign cs_fall   = ~s_cs_n & cs_q;
    assign addr_d    = ADDR_W'({addr_sh_q, s_mosi});
    assign rx_d      = {rx_q[DATA_W-2:0], s_mosi};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            sclk_q       <= 1'b0;
            cs_q         <= 1'b1;
            cmd_q        <= CMD_READ;
            bit_cnt_q    <= '0;
            addr_sh_q    <= '0;
            reg_addr_q   <= '0;
            rx_q         <= '0;
            tx_q         <= '0;
            reg_data_o_q <= '0;
            dv_q         <= 1'b0;
            load_q       <= 1'b0;
            inc_q        <= 1'b0;
        end else begin
            sclk_q <= s_sclk;
            cs_q   <= s_cs_n;
            dv_q   <= 1'b0;
            load_q <= 1'b0;
            inc_q  <= 1'b0;
            if (!ena || s_cs_n) begin
                state_q   <= ST_IDLE;
                bit_cnt_q <= '0;
            end else begin
                // Burst step: address advances one cycle after the word boundary, read prefetch follows
                if (inc_q) begin
                    reg_addr_q <= reg_addr_q + ADDR_W'(1);
                    load_q     <= (cmd_q == CMD_READ);
                end
                case (state_q)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state_q   <= ST_CMD;
                            bit_cnt_q <= '0;
                            tx_q      <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            cmd_q   <= s_mosi;
                            state_q <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        if (sclk_rise) begin
                            addr_sh_q <= addr_d;
                            if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
                                bit_cnt_q  <= '0;
                                reg_addr_q <= addr_d;
                                load_q     <= (cmd_q == CMD_READ);
                                state_q    <= ST_DATA;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sclk_rise) begin
                            rx_q <= rx_d;
                            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                                bit_cnt_q <= '0;
                                if (cmd_q == CMD_WRITE) begin
                                    reg_data_o_q <= rx_d;
                                    dv_q         <= 1'b1;
                                end
`ifdef SPI_REG_BRIDGE_BURST_EN
                                inc_q <= 1'b1;
`else
                                state_q <= ST_DONE;
`endif
                            end else begin
                                bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                            end
                        end else if (sclk_fall && bit_cnt_q != '0) begin
                            tx_q <= tx_q << 1;
                        end
                    end
                    ST_DONE: begin
                    end
                    default: state_q <= ST_IDLE;
                endcase
                if (load_q) begin
                    tx_q <= reg_data_i;
                end
            end
        end
    end

    assign spi_miso      = (state_q == ST_DATA) & tx_q[DATA_W-1];
    assign reg_addr      = reg_addr_q;
    assign reg_data_o    = reg_data_o_q;
    assign reg_data_o_dv = dv_q;
    assign reg_rd_strobe = load_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb/tb_spi_reg_bridge.sv - self-checking bench for spi_reg_bridge (ADDR_W=4, DATA_W=8)
module tb_spi_reg_bridge;

`ifdef SPI_REG_BRIDGE_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif
    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       rst_n, ena, spi_cs_n, spi_clk, spi_mosi;
    logic       spi_miso;
    logic [3:0] reg_addr;
    logic [7:0] reg_data_i, reg_data_o;
    logic       reg_data_o_dv, reg_rd_strobe;

    logic [7:0] mem [16];
    assign reg_data_i = mem[reg_addr];

    spi_reg_bridge #(.ADDR_W(4), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .spi_cs_n      (spi_cs_n),
        .spi_clk       (spi_clk),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .reg_addr      (reg_addr),
        .reg_data_i    (reg_data_i),
        .reg_data_o    (reg_data_o),
        .reg_data_o_dv (reg_data_o_dv),
        .reg_rd_strobe (reg_rd_strobe)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [11:0] dv_q [$];
    logic [3:0]  rs_q [$];
    logic [11:0] exp_dv [$];
    logic [3:0]  exp_rs [$];
    logic [31:0] exp_miso, got_miso;
    logic [3:0]  model_addr;

    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_data_o_dv) dv_q.push_back({reg_addr, reg_data_o});
            if (reg_rd_strobe) rs_q.push_back(reg_addr);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, output logic m);
        spi_mosi = b;
        wait_clks(HALF);
        spi_clk = 1'b1;
        m = spi_miso;
        wait_clks(HALF);
        spi_clk = 1'b0;
    endtask

    task automatic spi_frame(input logic cmd, input logic [3:0] a, input logic [31:0] words,
                             input int nbits, output logic [31:0] miso_bits);
        logic [36:0] stream;
        logic        m;
        stream    = {cmd, a, words};
        miso_bits = '0;
        spi_cs_n  = 1'b0;
        wait_clks(HALF);
        for (int i = 0; i < nbits; i++) begin
            spi_bit(stream[36-i], m);
            if (i >= 5) miso_bits = {miso_bits[30:0], m};
        end
        wait_clks(HALF);
        spi_cs_n = 1'b1;
        wait_clks(2 * HALF);
    endtask

    // Expected transactions from the frame rules: bits -> whole words -> addresses a, a+1, ...
    task automatic model_frame(input logic cmd, input logic [3:0] a, input logic [31:0] words,
                               input int nbits, input bit en);
        int ndata, full, k;
        exp_dv.delete();
        exp_rs.delete();
        exp_miso = '0;
        if (!en || nbits < 5) return;
        ndata = nbits - 5;
        full  = ndata / 8;
        if (!BURST && full > 1) full = 1;
        if (cmd) begin
            for (int w = 0; w < full; w++) exp_dv.push_back({4'(a + w), words[31 - 8*w -: 8]});
        end else begin
            exp_rs.push_back(a);
            if (BURST) for (int w = 0; w < full; w++) exp_rs.push_back(4'(a + w + 1));
        end
        for (int j = 0; j < ndata; j++) begin
            logic [7:0] wv;
            k  = j / 8;
            wv = (!BURST && k > 0) ? 8'h00 : mem[4'(a + k)];
            exp_miso = {exp_miso[30:0], wv[7 - (j % 8)]};
        end
        model_addr = BURST ? 4'(a + full) : a;
    endtask

    task automatic run_check(input string tag, input logic cmd, input logic [3:0] a,
                             input logic [31:0] words, input int nbits);
        dv_q.delete();
        rs_q.delete();
        model_frame(cmd, a, words, nbits, ena);
        spi_frame(cmd, a, words, nbits, got_miso);
        chk({tag, " dv_count"}, 64'(dv_q.size()), 64'(exp_dv.size()));
        for (int i = 0; i < exp_dv.size() && i < dv_q.size(); i++)
            chk($sformatf("%s dv[%0d]", tag, i), 64'(dv_q[i]), 64'(exp_dv[i]));
        chk({tag, " rs_count"}, 64'(rs_q.size()), 64'(exp_rs.size()));
        for (int i = 0; i < exp_rs.size() && i < rs_q.size(); i++)
            chk($sformatf("%s rs[%0d]", tag, i), 64'(rs_q[i]), 64'(exp_rs[i]));
        chk({tag, " final_addr"}, 64'(reg_addr), 64'(model_addr));
        if (!cmd && ena) chk({tag, " miso"}, 64'(got_miso), 64'(exp_miso));
    endtask

    typedef struct {
        logic        cmd;
        logic [3:0]  addr;
        logic [31:0] words;
        int          nbits;
        int          n_dv;
        logic [3:0]  dv_addr;
        logic [7:0]  dv_data;
        int          n_rs;
        logic [31:0] miso;
        logic [3:0]  final_addr;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic m;
        vecs[0] = '{1'b1, 4'h3, 32'hA500_0000, 13, 1, 4'h3, 8'hA5, 0, 32'h0, BURST ? 4'h4 : 4'h3};
        vecs[1] = '{1'b0, 4'h5, 32'h0,         13, 0, 4'h0, 8'h00, BURST ? 2 : 1, 32'h3C, BURST ? 4'h6 : 4'h5};
        vecs[2] = '{1'b1, 4'hF, 32'h1122_0000, 21, BURST ? 2 : 1, 4'hF, 8'h11, 0, 32'h0, BURST ? 4'h1 : 4'hF};
        vecs[3] = '{1'b1, 4'h7, 32'hFF00_0000, 10, 0, 4'h0, 8'h00, 0, 32'h0, 4'h7};
        vecs[4] = '{1'b1, 4'h2, 32'h5A00_0000, 13, 1, 4'h2, 8'h5A, 0, 32'h0, BURST ? 4'h3 : 4'h2};
        vecs[5] = '{1'b1, 4'h4, 32'h7788_0000, 21, BURST ? 2 : 1, 4'h4, 8'h77, 0, 32'h0, BURST ? 4'h6 : 4'h4};
        vecs[6] = '{1'b1, 4'h9, 32'h0,          3, 0, 4'h0, 8'h00, 0, 32'h0, BURST ? 4'h6 : 4'h4};

        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        mem[5] = 8'h3C;
        rst_n = 1'b0; ena = 1'b1; spi_cs_n = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
        model_addr = '0;
        wait_clks(3);
        chk("reset miso", 64'(spi_miso), 64'h0);
        chk("reset addr", 64'(reg_addr), 64'h0);
        chk("reset data_o", 64'(reg_data_o), 64'h0);
        chk("reset dv", 64'(reg_data_o_dv), 64'h0);
        chk("reset rd_strobe", 64'(reg_rd_strobe), 64'h0);
        rst_n = 1'b1;
        wait_clks(4);

        for (int i = 0; i < 7; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            run_check(tag, vecs[i].cmd, vecs[i].addr, vecs[i].words, vecs[i].nbits);
            chk({tag, " tbl_dv_count"}, 64'(dv_q.size()), 64'(vecs[i].n_dv));
            if (vecs[i].n_dv > 0)
                chk({tag, " tbl_dv0"}, 64'(dv_q.size() > 0 ? dv_q[0] : 12'hxxx),
                    64'({vecs[i].dv_addr, vecs[i].dv_data}));
            chk({tag, " tbl_rs_count"}, 64'(rs_q.size()), 64'(vecs[i].n_rs));
            if (!vecs[i].cmd) chk({tag, " tbl_miso"}, 64'(got_miso), 64'(vecs[i].miso));
            chk({tag, " tbl_final_addr"}, 64'(reg_addr), 64'(vecs[i].final_addr));
        end

        // Bridge disabled: frame must be ignored entirely
        ena = 1'b0;
        run_check("ena_off", 1'b1, 4'hB, 32'hCC00_0000, 13);
        ena = 1'b1;
        wait_clks(4);

        // Asynchronous reset in the middle of a read data word
        mem[6] = 8'hA7;
        spi_cs_n = 1'b0;
        wait_clks(HALF);
        for (int i = 0; i < 8; i++) spi_bit((i == 2 || i == 3) ? 1'b1 : 1'b0, m);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid miso", 64'(spi_miso), 64'h0);
        chk("rst_mid dv", 64'(reg_data_o_dv), 64'h0);
        chk("rst_mid rd_strobe", 64'(reg_rd_strobe), 64'h0);
        chk("rst_mid addr", 64'(reg_addr), 64'h0);
        spi_cs_n = 1'b1;
        wait_clks(3);
        rst_n = 1'b1;
        model_addr = '0;
        wait_clks(4);
        mem[1] = 8'($urandom);
        run_check("post_rst_read", 1'b0, 4'h1, 32'h0, 13);

        for (int r = 0; r < 20; r++) begin
            logic        cmd;
            logic [3:0]  a;
            logic [31:0] w;
            int          nb;
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
            cmd = 1'($urandom);
            a   = 4'($urandom);
            w   = $urandom;
            nb  = 5 + 8 * $urandom_range(0, 3);
            if ($urandom_range(0, 2) == 0) nb = nb + $urandom_range(1, 7);
            if ($urandom_range(0, 7) == 0) nb = $urandom_range(1, 4);
            run_check($sformatf("rand%0d", r), cmd, a, w, nb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
